// File: rtl/dcache_mem_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dcache_mem_responder_pkg
// Brief    : Shared constants for the data-cache memory responder: FSM state
//            encoding, line geometry and out-of-range fill pattern.
// Revision : 1.0 - initial release
// ============================================================================
package dcache_mem_responder_pkg;

    localparam int c_LINE_BYTES = 16;
    localparam int c_LINE_BITS  = 8 * c_LINE_BYTES;

    localparam logic [2:0] c_ST_IDLE    = 3'd0;
    localparam logic [2:0] c_ST_WR_EXEC = 3'd1;
    localparam logic [2:0] c_ST_RD_WAIT = 3'd2;
    localparam logic [2:0] c_ST_RD_DATA = 3'd3;
    localparam logic [2:0] c_ST_RD_FIN  = 3'd4;

    localparam logic [c_LINE_BITS-1:0] c_OOR_FILL = {4{32'hDEADBEEF}};

endpackage
`default_nettype wire

// File: rtl/dcmem_line_ram.sv
`default_nettype none
// ============================================================================
// Module   : dcmem_line_ram
// Brief    : 2**AWIDTH x 128-bit single-port synchronous line RAM with byte
//            enables; read data register holds until the next read.
// Revision : 1.0 - initial release
// ============================================================================
module dcmem_line_ram
    import dcache_mem_responder_pkg::*;
#(
    parameter int AWIDTH = 10
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    i_en,
    input  logic                    i_we,
    input  logic [AWIDTH-1:0]       i_addr,
    input  logic [c_LINE_BYTES-1:0] i_be,
    input  logic [c_LINE_BITS-1:0]  i_wdata,
    output logic [c_LINE_BITS-1:0]  o_rdata
);

    logic [c_LINE_BITS-1:0] r_mem [2**AWIDTH];
    logic [c_LINE_BITS-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_en && i_we) begin
            for (int b = 0; b < c_LINE_BYTES; b++) begin
                if (i_be[b]) begin
                    r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
                end
            end
        end
    end

    // Writes leave the read register untouched so returned data stays stable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdata <= '0;
        end else if (i_en && !i_we) begin
            r_rdata <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/dcache_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : dcache_mem_responder
// Brief    : Memory-side responder for the data-cache line interface; serialises
//            masked line writes and line reads onto one backing RAM.
// Config   : define DCMEM_RANGE_CHK_EN to flag addresses beyond the RAM range.
// Revision : 1.0 - initial release
// ============================================================================
module dcache_mem_responder
    import dcache_mem_responder_pkg::*;
#(
    parameter int MWIDTH = 10,
    parameter int RD_LAT = 4,
    parameter int WR_LAT = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         dcw_start_rq,
    input  logic [31:0]  dcw_in_addr,
    input  logic [15:0]  dcw_in_mask,
    input  logic [127:0] dcw_in_data,
    output logic         dcw_finish_wresp,
    input  logic         dcr_start_rq,
    input  logic [31:0]  dcr_rin_addr,
    input  logic         rqfull_1,
    output logic [127:0] rdat_m_data,
    output logic         rdat_m_valid,
    output logic         finish_mrd
);

    localparam int c_CNT_MAX = (RD_LAT > WR_LAT) ? RD_LAT : WR_LAT;
    localparam int c_CNT_W   = $clog2(c_CNT_MAX + 1);

    logic [2:0]         r_state;
    logic [2:0]         w_state_nxt;
    logic [c_CNT_W-1:0] r_cnt;

    logic               r_wr_valid;
    logic               r_wr_oor;
    logic [MWIDTH-1:0]  r_wr_line;
    logic [15:0]        r_wr_mask;
    logic [127:0]       r_wr_data;
    logic               r_rd_valid;
    logic               r_rd_oor;
    logic [MWIDTH-1:0]  r_rd_line;

    logic               r_rd_oor_q;
    logic               r_wresp;

    logic               w_wr_oor_in;
    logic               w_rd_oor_in;
    logic               w_unused;
    logic               w_wr_req;
    logic               w_rd_req;
    logic               w_wr_accept;
    logic               w_rd_accept;
    logic               w_wr_free;
    logic               w_rd_free;
    logic               w_wr_last;
    logic               w_rd_last;
    logic               w_wr_done;
    logic               w_valid;
    logic               w_finish;
    logic               w_ram_en;
    logic               w_ram_we;
    logic [MWIDTH-1:0]  w_ram_addr;
    logic [127:0]       w_ram_q;

`ifdef DCMEM_RANGE_CHK_EN
    assign w_wr_oor_in = |dcw_in_addr[31:MWIDTH+4];
    assign w_rd_oor_in = |dcr_rin_addr[31:MWIDTH+4];
    assign w_unused    = ^{dcw_in_addr[3:0], dcr_rin_addr[3:0]};
`else
    assign w_wr_oor_in = 1'b0;
    assign w_rd_oor_in = 1'b0;
    assign w_unused    = ^{dcw_in_addr[31:MWIDTH+4], dcw_in_addr[3:0],
                           dcr_rin_addr[31:MWIDTH+4], dcr_rin_addr[3:0]};
`endif

    // An incoming pulse counts as pending so an idle FSM picks it up at once.
    assign w_wr_req    = r_wr_valid | dcw_start_rq;
    assign w_rd_req    = r_rd_valid | dcr_start_rq;
    assign w_wr_free   = w_wr_done;
    assign w_rd_free   = (r_state == c_ST_RD_FIN);
    assign w_wr_accept = dcw_start_rq && (!r_wr_valid || w_wr_free);
    assign w_rd_accept = dcr_start_rq && (!r_rd_valid || w_rd_free);
    assign w_wr_last   = (r_cnt == c_CNT_W'(WR_LAT - 1));
    assign w_rd_last   = (r_cnt == c_CNT_W'(RD_LAT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_valid <= 1'b0;
            r_wr_oor   <= 1'b0;
            r_wr_line  <= '0;
            r_wr_mask  <= '0;
            r_wr_data  <= '0;
            r_rd_valid <= 1'b0;
            r_rd_oor   <= 1'b0;
            r_rd_line  <= '0;
        end else begin
            if (w_wr_accept) begin
                r_wr_valid <= 1'b1;
                r_wr_oor   <= w_wr_oor_in;
                r_wr_line  <= dcw_in_addr[MWIDTH+3:4];
                r_wr_mask  <= dcw_in_mask;
                r_wr_data  <= dcw_in_data;
            end else if (w_wr_free) begin
                r_wr_valid <= 1'b0;
            end
            if (w_rd_accept) begin
                r_rd_valid <= 1'b1;
                r_rd_oor   <= w_rd_oor_in;
                r_rd_line  <= dcr_rin_addr[MWIDTH+3:4];
            end else if (w_rd_free) begin
                r_rd_valid <= 1'b0;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_wr_done   = 1'b0;
        w_valid     = 1'b0;
        w_finish    = 1'b0;
        w_ram_en    = 1'b0;
        w_ram_we    = 1'b0;
        w_ram_addr  = r_rd_line;
        case (r_state)
            c_ST_IDLE: begin
                if (w_wr_req) begin
                    w_state_nxt = c_ST_WR_EXEC;
                end else if (w_rd_req) begin
                    w_state_nxt = c_ST_RD_WAIT;
                end
            end
            c_ST_WR_EXEC: begin
                w_ram_addr = r_wr_line;
                w_ram_we   = 1'b1;
                w_ram_en   = (r_cnt == '0) && !r_wr_oor;
                if (w_wr_last) begin
                    w_wr_done   = 1'b1;
                    w_state_nxt = c_ST_IDLE;
                end
            end
            c_ST_RD_WAIT: begin
                w_ram_en = (r_cnt == '0);
                if (w_rd_last) begin
                    w_state_nxt = c_ST_RD_DATA;
                end
            end
            c_ST_RD_DATA: begin
                if (!rqfull_1) begin
                    w_valid     = 1'b1;
                    w_state_nxt = c_ST_RD_FIN;
                end
            end
            c_ST_RD_FIN: begin
                w_finish    = 1'b1;
                w_state_nxt = c_ST_IDLE;
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= c_ST_IDLE;
            r_cnt      <= '0;
            r_wresp    <= 1'b0;
            r_rd_oor_q <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_wresp <= w_wr_done;
            if (w_state_nxt != r_state) begin
                r_cnt <= '0;
            end else if (r_cnt != c_CNT_W'(c_CNT_MAX)) begin
                r_cnt <= r_cnt + c_CNT_W'(1);
            end
            if ((r_state == c_ST_RD_WAIT) && (r_cnt == '0)) begin
                r_rd_oor_q <= r_rd_oor;
            end
        end
    end

    dcmem_line_ram #(
        .AWIDTH (MWIDTH)
    ) u_ram (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_en    (w_ram_en),
        .i_we    (w_ram_we),
        .i_addr  (w_ram_addr),
        .i_be    (r_wr_mask),
        .i_wdata (r_wr_data),
        .o_rdata (w_ram_q)
    );

    assign dcw_finish_wresp = r_wresp;
    assign rdat_m_valid     = w_valid;
    assign finish_mrd       = w_finish;
    assign rdat_m_data      = r_rd_oor_q ? c_OOR_FILL : w_ram_q;

    a_wr_slot_overrun: assert property (@(posedge clk) disable iff (!rst_n)
        !(dcw_start_rq && r_wr_valid && !w_wr_free))
        else $error("dcache_mem_responder: write request dropped, slot occupied");

    a_rd_slot_overrun: assert property (@(posedge clk) disable iff (!rst_n)
        !(dcr_start_rq && r_rd_valid && !w_rd_free))
        else $error("dcache_mem_responder: read request dropped, slot occupied");

endmodule
`default_nettype wire

// File: tb/tb_dcache_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_dcache_mem_responder
// Brief    : Self-checking bench: directed vector table, multi-cycle corner
//            sequences and randomized traffic against a line-array model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dcache_mem_responder;

    localparam int MWIDTH = 10;
    localparam int RD_LAT = 4;
    localparam int WR_LAT = 2;
    localparam logic [127:0] c_FILL = {4{32'hDEADBEEF}};
    localparam logic [127:0] c_D0   = 128'h0123456789ABCDEF_0123456789ABCDEF;
    localparam logic [127:0] c_ONES = {128{1'b1}};

    logic         clk = 1'b0;
    logic         rst_n;
    logic         dcw_start_rq;
    logic [31:0]  dcw_in_addr;
    logic [15:0]  dcw_in_mask;
    logic [127:0] dcw_in_data;
    logic         dcw_finish_wresp;
    logic         dcr_start_rq;
    logic [31:0]  dcr_rin_addr;
    logic         rqfull_1;
    logic [127:0] rdat_m_data;
    logic         rdat_m_valid;
    logic         finish_mrd;

    always #5 clk = ~clk;

    dcache_mem_responder #(
        .MWIDTH (MWIDTH),
        .RD_LAT (RD_LAT),
        .WR_LAT (WR_LAT)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .dcw_start_rq     (dcw_start_rq),
        .dcw_in_addr      (dcw_in_addr),
        .dcw_in_mask      (dcw_in_mask),
        .dcw_in_data      (dcw_in_data),
        .dcw_finish_wresp (dcw_finish_wresp),
        .dcr_start_rq     (dcr_start_rq),
        .dcr_rin_addr     (dcr_rin_addr),
        .rqfull_1         (rqfull_1),
        .rdat_m_data      (rdat_m_data),
        .rdat_m_valid     (rdat_m_valid),
        .finish_mrd       (finish_mrd)
    );

    int tests = 0;
    int fails = 0;
    logic [127:0] model [1 << MWIDTH];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic bit is_oor(input logic [31:0] a);
`ifdef DCMEM_RANGE_CHK_EN
        return (a >> (MWIDTH + 4)) != 0;
`else
        return 1'b0;
`endif
    endfunction

    function automatic int line_of(input logic [31:0] a);
        return int'((a / 16) % (1 << MWIDTH));
    endfunction

    task automatic model_write(input logic [31:0] a, input logic [15:0] m, input logic [127:0] d);
        if (!is_oor(a)) begin
            for (int b = 0; b < 16; b++) begin
                if (m[b]) model[line_of(a)][8*b +: 8] = d[8*b +: 8];
            end
        end
    endtask

    function automatic logic [127:0] model_read(input logic [31:0] a);
        return is_oor(a) ? c_FILL : model[line_of(a)];
    endfunction

    task automatic do_write(input logic [31:0] a, input logic [15:0] m, input logic [127:0] d,
                            output int lat, output int cnt);
        lat = -1;
        cnt = 0;
        dcw_in_addr  = a;
        dcw_in_mask  = m;
        dcw_in_data  = d;
        dcw_start_rq = 1'b1;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk);
            #1;
            if (n == 1) dcw_start_rq = 1'b0;
            #1;
            if (dcw_finish_wresp) begin
                cnt++;
                if (lat < 0) lat = n;
            end
            if (lat > 0 && n >= lat + 2) break;
        end
        model_write(a, m, d);
    endtask

    task automatic read_and_check(input string tag, input logic [31:0] a, input int hold,
                                  input logic [127:0] exp);
        int vlat, flat, vcnt, fcnt;
        logic [127:0] data;
        vlat = -1;
        flat = -1;
        vcnt = 0;
        fcnt = 0;
        data = '0;
        dcr_rin_addr = a;
        dcr_start_rq = 1'b1;
        rqfull_1     = (hold > 0);
        for (int n = 1; n <= 80; n++) begin
            @(posedge clk);
            #1;
            if (n == 1) dcr_start_rq = 1'b0;
            rqfull_1 = (hold > 0) && (n < RD_LAT + 1 + hold);
            #1;
            if (rdat_m_valid) begin
                vcnt++;
                if (vlat < 0) begin
                    vlat = n;
                    data = rdat_m_data;
                end
            end
            if (finish_mrd) begin
                fcnt++;
                if (flat < 0) flat = n;
            end
            if (flat > 0 && n >= flat + 3) break;
        end
        rqfull_1 = 1'b0;
        check_int({tag, " valid_latency"}, vlat, RD_LAT + 1 + hold);
        check_int({tag, " finish_latency"}, flat, RD_LAT + 2 + hold);
        check_int({tag, " valid_count"}, vcnt, 1);
        check_int({tag, " finish_count"}, fcnt, 1);
        check({tag, " data"}, data, exp);
        check({tag, " held_data"}, rdat_m_data, exp);
    endtask

    typedef struct {
        bit           wr;
        logic [31:0]  addr;
        logic [15:0]  mask;
        logic [127:0] data;
        int           hold;
        logic [127:0] exp;
    } vec_t;

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        vec_t vecs[$];
        int lat, cnt, wl, vl, fl, pulses;
        logic [127:0] d1, d2, d3, rdata, exp;
        logic [31:0] a;
        logic [15:0] m;
        int line, hold;

        vecs.push_back('{1'b1, 32'h100, 16'hFFFF, c_D0, 0, 128'h0});
        vecs.push_back('{1'b0, 32'h100, 16'h0000, 128'h0, 0, c_D0});
        vecs.push_back('{1'b1, 32'h200, 16'hFFFF, c_ONES, 0, 128'h0});
        vecs.push_back('{1'b1, 32'h200, 16'h000F, 128'h0, 0, 128'h0});
        vecs.push_back('{1'b0, 32'h200, 16'h0000, 128'h0, 0, {96'hFFFFFFFF_FFFFFFFF_FFFFFFFF, 32'h0}});
        vecs.push_back('{1'b1, 32'h20C, 16'h0000, 128'h0, 0, 128'h0});
        vecs.push_back('{1'b0, 32'h208, 16'h0000, 128'h0, 0, {96'hFFFFFFFF_FFFFFFFF_FFFFFFFF, 32'h0}});
        vecs.push_back('{1'b0, 32'h100, 16'h0000, 128'h0, 10, c_D0});
        vecs.push_back('{1'b1, 32'h104, 16'hF0F0, {16{8'hA5}}, 0, 128'h0});
        vecs.push_back('{1'b0, 32'h10F, 16'h0000, 128'h0, 3, 128'hA5A5A5A5_89ABCDEF_A5A5A5A5_89ABCDEF});

        rst_n        = 1'b0;
        dcw_start_rq = 1'b0;
        dcw_in_addr  = '0;
        dcw_in_mask  = '0;
        dcw_in_data  = '0;
        dcr_start_rq = 1'b0;
        dcr_rin_addr = '0;
        rqfull_1     = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_int("reset wresp", int'(dcw_finish_wresp), 0);
        check_int("reset valid", int'(rdat_m_valid), 0);
        check_int("reset finish", int'(finish_mrd), 0);
        check("reset rdata", rdat_m_data, 128'h0);
        rst_n = 1'b1;
        @(posedge clk);
        #2;

        // Directed vector table
        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].wr) begin
                do_write(vecs[i].addr, vecs[i].mask, vecs[i].data, lat, cnt);
                check_int($sformatf("vec%0d wresp_latency", i), lat, WR_LAT + 1);
                check_int($sformatf("vec%0d wresp_count", i), cnt, 1);
            end else begin
                read_and_check($sformatf("vec%0d", i), vecs[i].addr, vecs[i].hold, vecs[i].exp);
            end
        end

        // Same-cycle write and read to one line: write must land first
        do_write(32'h300, 16'hFFFF, 128'h0, lat, cnt);
        d1 = 128'hCAFEF00D_12345678_9ABCDEF0_0F1E2D3C;
        dcw_in_addr  = 32'h300;
        dcw_in_mask  = 16'hFFFF;
        dcw_in_data  = d1;
        dcr_rin_addr = 32'h300;
        dcw_start_rq = 1'b1;
        dcr_start_rq = 1'b1;
        wl = -1; vl = -1; fl = -1; rdata = '0;
        for (int n = 1; n <= 60; n++) begin
            @(posedge clk);
            #1;
            if (n == 1) begin
                dcw_start_rq = 1'b0;
                dcr_start_rq = 1'b0;
            end
            #1;
            if (dcw_finish_wresp && wl < 0) wl = n;
            if (rdat_m_valid && vl < 0) begin
                vl = n;
                rdata = rdat_m_data;
            end
            if (finish_mrd && fl < 0) fl = n;
            if (fl > 0 && n >= fl + 2) break;
        end
        model_write(32'h300, 16'hFFFF, d1);
        check_int("same_cycle wresp_latency", wl, WR_LAT + 1);
        check_int("same_cycle valid_latency", vl, WR_LAT + 1 + RD_LAT + 1);
        check_int("same_cycle finish_latency", fl, WR_LAT + 1 + RD_LAT + 2);
        check("same_cycle data", rdata, d1);

        // Reset pulsed while a read waits on latency
        dcr_rin_addr = 32'h300;
        dcr_start_rq = 1'b1;
        @(posedge clk);
        #1;
        dcr_start_rq = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_int("midreset valid", int'(rdat_m_valid), 0);
        check_int("midreset finish", int'(finish_mrd), 0);
        check_int("midreset wresp", int'(dcw_finish_wresp), 0);
        check("midreset rdata", rdat_m_data, 128'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        pulses = 0;
        repeat (12) begin
            @(posedge clk);
            #2;
            if (rdat_m_valid || finish_mrd || dcw_finish_wresp) pulses++;
        end
        check_int("midreset stray_pulses", pulses, 0);
        read_and_check("after_reset", 32'h300, 0, model_read(32'h300));

        // Upper address bits: aliasing or range check
        d2 = 128'h11112222_33334444_55556666_77778888;
        d3 = 128'h99990000_AAAABBBB_CCCCDDDD_EEEEFFFF;
        do_write(32'h0, 16'hFFFF, d2, lat, cnt);
        check_int("line0 wresp_latency", lat, WR_LAT + 1);
        read_and_check("high_read", 32'h0001_0000, 0, model_read(32'h0001_0000));
        do_write(32'h0001_0000, 16'hFFFF, d3, lat, cnt);
        check_int("high_write wresp_latency", lat, WR_LAT + 1);
        check_int("high_write wresp_count", cnt, 1);
        read_and_check("line0_after_high", 32'h0, 0, model_read(32'h0));

        // Randomized traffic over a small set of lines
        for (int i = 0; i < 8; i++) begin
            d1 = {$urandom, $urandom, $urandom, $urandom};
            do_write(32'((16'h80 + i) * 16), 16'hFFFF, d1, lat, cnt);
            check_int($sformatf("rnd_init%0d wresp_latency", i), lat, WR_LAT + 1);
        end
        for (int i = 0; i < 40; i++) begin
            line = 16'h80 + $urandom_range(0, 7);
            a    = 32'(line * 16 + $urandom_range(0, 15));
            if ($urandom_range(0, 1) == 1) begin
                m  = 16'($urandom);
                d1 = {$urandom, $urandom, $urandom, $urandom};
                do_write(a, m, d1, lat, cnt);
                check_int($sformatf("rnd%0d wresp_latency", i), lat, WR_LAT + 1);
                check_int($sformatf("rnd%0d wresp_count", i), cnt, 1);
            end else begin
                hold = $urandom_range(0, 3);
                exp  = model_read(a);
                read_and_check($sformatf("rnd%0d", i), a, hold, exp);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
